// File: rtl/riscv_v_ext_csr_arb_if.sv
// Requester and CSR write-bus bundle for the vector CSR write-port arbiter.
// slave: the arbiter side. master: the side that issues requests and watches the bus.
interface riscv_v_ext_csr_arb_if #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [3*NUM_REQ-1:0]      req_sel;
  logic [DATA_W*NUM_REQ-1:0] req_data;
  logic [DATA_W*NUM_REQ-1:0] req_data2;
  logic [DATA_W-1:0]         ext_csr_data;
  logic                      ext_wr_vsstatus;
  logic                      ext_wr_vtype;
  logic                      ext_wr_vl;
  logic                      ext_wr_vstart;
  logic                      ext_wr_vxrm;
  logic                      ext_wr_vxsat;
  logic                      busy;
  logic                      err;

  modport slave (
    input  req_valid, req_sel, req_data, req_data2,
    output req_ready, ext_csr_data,
    output ext_wr_vsstatus, ext_wr_vtype, ext_wr_vl, ext_wr_vstart, ext_wr_vxrm, ext_wr_vxsat,
    output busy, err
  );

  modport master (
    output req_valid, req_sel, req_data, req_data2,
    input  req_ready, ext_csr_data,
    input  ext_wr_vsstatus, ext_wr_vtype, ext_wr_vl, ext_wr_vstart, ext_wr_vxrm, ext_wr_vxsat,
    input  busy, err
  );
endinterface

// File: rtl/riscv_v_ext_csr_arb.sv
// Round-robin arbiter for the vector-extension external CSR write port.
// A VSETVL request is split into an uninterruptible vtype beat followed by a vl beat.
//
//   state | meaning
//   IDLE  | arbitrate among requesters, one accept per cycle
//   PAIR  | vtype beat on the bus, vl beat issues next cycle, no grants
module riscv_v_ext_csr_arb #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  riscv_v_ext_csr_arb_if.slave bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [2:0] SEL_VSETVL = 3'd6;
  localparam logic [2:0] SEL_RSVD   = 3'd7;

  typedef enum logic {IDLE, PAIR} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [DATA_W-1:0]  vlbuf_q, vlbuf_d;
  logic [5:0]         strb_q, strb_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  logic               gnt_vld;
  logic [PTR_W-1:0]   gnt_idx;
  logic [2:0]         win_sel;
  logic [DATA_W-1:0]  win_data;
  logic [DATA_W-1:0]  win_data2;

  // Rotating-priority search from the pointer; grants are suppressed in reset and PAIR.
  always_comb begin
    int               idx;
    logic [PTR_W-1:0] cand;
    idx       = 0;
    cand      = '0;
    gnt_vld   = 1'b0;
    gnt_idx   = '0;
    win_sel   = '0;
    win_data  = '0;
    win_data2 = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = PTR_W'(idx);
      if (!gnt_vld && bus.req_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    if (rst || state_q != IDLE) gnt_vld = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == PTR_W'(i)) begin
        win_sel   = bus.req_sel[i*3 +: 3];
        win_data  = bus.req_data[i*DATA_W +: DATA_W];
        win_data2 = bus.req_data2[i*DATA_W +: DATA_W];
      end
    end
    bus.req_ready = '0;
    if (gnt_vld) bus.req_ready[gnt_idx] = 1'b1;
  end

  // Next state, pointer and registered bus outputs.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    vlbuf_d = vlbuf_q;
    strb_d  = '0;
    busy_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          if (win_sel == SEL_VSETVL) begin
            data_d    = win_data;
            vlbuf_d   = win_data2;
            strb_d[1] = 1'b1;
            busy_d    = 1'b1;
            state_d   = PAIR;
          end else if (win_sel == SEL_RSVD) begin
            err_d = 1'b1;
          end else begin
            data_d = win_data;
            strb_d = 6'd1 << win_sel;
          end
        end
      end
      PAIR: begin
        data_d    = vlbuf_q;
        strb_d[2] = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      data_q  <= '0;
      vlbuf_q <= '0;
      strb_q  <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      vlbuf_q <= vlbuf_d;
      strb_q  <= strb_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign bus.ext_csr_data    = data_q;
  assign bus.ext_wr_vsstatus = strb_q[0];
  assign bus.ext_wr_vtype    = strb_q[1];
  assign bus.ext_wr_vl       = strb_q[2];
  assign bus.ext_wr_vstart   = strb_q[3];
  assign bus.ext_wr_vxrm     = strb_q[4];
  assign bus.ext_wr_vxsat    = strb_q[5];
  assign bus.busy            = busy_q;
  assign bus.err             = err_q;

endmodule

// File: tb/tb_riscv_v_ext_csr_arb.sv
// Bench for the vector CSR write-port arbiter: directed scenarios plus random traffic,
// all checked against a write-schedule model of the bus.
module tb_riscv_v_ext_csr_arb;
  localparam int N = 3;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  riscv_v_ext_csr_arb_if #(.NUM_REQ(N), .DATA_W(W)) bus ();
  riscv_v_ext_csr_arb #(.NUM_REQ(N), .DATA_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: writes scheduled onto the bus, one per cycle; kind 0..5 strobe index, 6 error.
  typedef struct {
    int           kind;
    logic [W-1:0] data;
    bit           busy;
  } wr_t;

  wr_t          sched[$];
  int           ptr = 0;
  logic [W-1:0] last_data = '0;
  logic [N-1:0] last_ready;

  function automatic wr_t mk(input int kind, input logic [W-1:0] data, input bit bsy);
    wr_t w;
    w.kind = kind;
    w.data = data;
    w.busy = bsy;
    return w;
  endfunction

  // A pending scheduled write means the bus is owned by a VSETVL pair.
  function automatic int pick();
    if (rst || sched.size() != 0) return -1;
    for (int k = 0; k < N; k++) begin
      if (bus.req_valid[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [5:0] strobes();
    return {bus.ext_wr_vxsat, bus.ext_wr_vxrm, bus.ext_wr_vstart,
            bus.ext_wr_vl, bus.ext_wr_vtype, bus.ext_wr_vsstatus};
  endfunction

  task automatic set_req(input int i, input logic [2:0] sel, input logic [W-1:0] d, input logic [W-1:0] d2);
    bus.req_sel[i*3 +: 3]   = sel;
    bus.req_data[i*W +: W]  = d;
    bus.req_data2[i*W +: W] = d2;
  endtask

  // One clock: check ready before the edge, advance the model, check the bus after it.
  task automatic cycle();
    int         g;
    wr_t        cur;
    bit         have;
    logic [2:0] s;
    logic [5:0] exp_strb;
    #1;
    g = pick();
    last_ready = bus.req_ready;
    chk("ready", 64'(last_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
    @(posedge clk);
    have = 1'b0;
    if (rst) begin
      sched.delete();
      ptr = 0;
      last_data = '0;
    end else begin
      if (g >= 0) begin
        s = bus.req_sel[g*3 +: 3];
        if (s == 3'd6) begin
          sched.push_back(mk(1, bus.req_data[g*W +: W], 1'b1));
          sched.push_back(mk(2, bus.req_data2[g*W +: W], 1'b0));
        end else if (s == 3'd7) begin
          sched.push_back(mk(6, '0, 1'b0));
        end else begin
          sched.push_back(mk(int'(s), bus.req_data[g*W +: W], 1'b0));
        end
        ptr = (g + 1) % N;
      end
      if (sched.size() > 0) begin
        cur = sched.pop_front();
        have = 1'b1;
      end
    end
    #1;
    exp_strb = '0;
    if (have && cur.kind < 6) begin
      exp_strb = 6'd1 << cur.kind;
      last_data = cur.data;
    end
    chk("strobes", 64'(strobes()), 64'(exp_strb));
    chk("onehot0", 64'($onehot0(strobes())), 64'd1);
    chk("data", 64'(bus.ext_csr_data), 64'(last_data));
    chk("busy", 64'(bus.busy), 64'(have && cur.busy));
    chk("err", 64'(bus.err), 64'(have && cur.kind == 6));
    @(negedge clk);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_sel   = '0;
    bus.req_data  = '0;
    bus.req_data2 = '0;
    rst = 1'b1;
    cycle();
    cycle();
    chk("rst_data", 64'(bus.ext_csr_data), 64'd0);
    rst = 1'b0;

    // Round robin with all three requesters held valid.
    for (int i = 0; i < N; i++) set_req(i, 3'd3, W'(i), '0);
    bus.req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("rr_gnt", 64'(last_ready), 64'd1 << (k % 3));
      chk("rr_vstart", 64'(bus.ext_wr_vstart), 64'd1);
      chk("rr_data", 64'(bus.ext_csr_data), 64'(k % 3));
    end

    // Single vl write, then data holds.
    bus.req_valid = 3'b001;
    set_req(0, 3'd2, 32'h10, '0);
    cycle();
    chk("single_vl", 64'(bus.ext_wr_vl), 64'd1);
    chk("single_data", 64'(bus.ext_csr_data), 64'h10);
    bus.req_valid = '0;
    cycle();
    chk("single_idle", 64'(strobes()), 64'd0);
    chk("single_hold", 64'(bus.ext_csr_data), 64'h10);

    // VSETVL pair from req1 while req0 waits with a vxrm write.
    set_req(0, 3'd4, 32'h44, '0);
    set_req(1, 3'd6, 32'hD0, 32'h8);
    bus.req_valid = 3'b011;
    cycle();
    chk("pair_gnt", 64'(last_ready), 64'b010);
    chk("pair_vtype", 64'(bus.ext_wr_vtype), 64'd1);
    chk("pair_vtype_data", 64'(bus.ext_csr_data), 64'hD0);
    chk("pair_busy", 64'(bus.busy), 64'd1);
    cycle();
    chk("pair_block", 64'(last_ready), 64'd0);
    chk("pair_vl", 64'(bus.ext_wr_vl), 64'd1);
    chk("pair_vl_data", 64'(bus.ext_csr_data), 64'h8);
    cycle();
    chk("pair_next_gnt", 64'(last_ready), 64'b001);
    chk("pair_vxrm", 64'(bus.ext_wr_vxrm), 64'd1);
    chk("pair_vxrm_data", 64'(bus.ext_csr_data), 64'h44);
    bus.req_valid = '0;

    // Reserved select from req2.
    set_req(2, 3'd7, 32'hDEAD, '0);
    bus.req_valid = 3'b100;
    cycle();
    chk("rsvd_gnt", 64'(last_ready), 64'b100);
    chk("rsvd_nostrb", 64'(strobes()), 64'd0);
    chk("rsvd_err", 64'(bus.err), 64'd1);
    bus.req_valid = '0;
    cycle();
    chk("rsvd_err_end", 64'(bus.err), 64'd0);

    // Reset asserted during the PAIR cycle.
    set_req(1, 3'd6, 32'hAB, 32'hCD);
    bus.req_valid = 3'b010;
    cycle();
    bus.req_valid = '0;
    rst = 1'b1;
    cycle();
    chk("rstpair_novl", 64'(bus.ext_wr_vl), 64'd0);
    chk("rstpair_busy", 64'(bus.busy), 64'd0);
    chk("rstpair_data", 64'(bus.ext_csr_data), 64'd0);
    rst = 1'b0;
    set_req(0, 3'd0, 32'h5, '0);
    set_req(1, 3'd0, 32'h6, '0);
    bus.req_valid = 3'b011;
    cycle();
    chk("rstpair_ptr", 64'(last_ready), 64'b001);

    // Idle hold after a vxsat write.
    bus.req_valid = 3'b001;
    set_req(0, 3'd5, 32'h1, '0);
    cycle();
    bus.req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("idle_strb", 64'(strobes()), 64'd0);
      chk("idle_data", 64'(bus.ext_csr_data), 64'h1);
    end

    // Random traffic with occasional resets.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        bus.req_valid[i] = ($urandom_range(0, 9) < 6);
        set_req(i, 3'($urandom_range(0, 7)), $urandom(), $urandom());
      end
      rst = ($urandom_range(0, 49) == 0);
      cycle();
    end
    rst = 1'b0;
    bus.req_valid = '0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
